// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port between N requesters, with an optional wait-state timeout.
// Transfer: req sampled in IDLE -> SETUP -> ACCESS (waits on PREADY) -> IDLE with a one-cycle done pulse.
module apb_rr_arbiter #(
  parameter int N       = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic            err,
  output logic [DW-1:0]   rdata,
  output logic            PSEL,
  output logic            PENABLE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  output logic            PWRITE,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    gnt_q;
  logic [N-1:0]    done_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;
  logic            psel_q;
  logic            penable_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic            pwrite_q;

  logic [IW-1:0]   win_d;
  logic            found_d;
  logic [CW-1:0]   cnt_d;
  logic            timeout_hit;
  logic [IW-1:0]   ptr_adv;

  // First requester at or above the pointer, wrapping N-1 -> 0.
  always_comb begin
    win_d   = ptr_q;
    found_d = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found_d && req[(int'(ptr_q) + k) % N]) begin
        found_d = 1'b1;
        win_d   = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_d == TO_LIM);
  assign ptr_adv     = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            state_q   <= S_SETUP;
            win_q     <= win_d;
            gnt_q     <= N'(1) << win_d;
            cnt_q     <= '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= req_addr[int'(win_d) * AW +: AW];
            pwdata_q  <= req_wdata[int'(win_d) * DW +: DW];
            pwrite_q  <= req_write[win_d];
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          // A ready slave wins over a timeout landing on the same cycle.
          if (PREADY || timeout_hit) begin
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            gnt_q     <= '0;
            done_q    <= gnt_q;
            err_q     <= !PREADY;
            ptr_q     <= ptr_adv;
            if (!PREADY) begin
              rdata_q <= '0;
            end else if (!pwrite_q) begin
              rdata_q <= PRDATA;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;

endmodule
